// File: rtl/video_pix_packer.sv
// Packs de-qualified PIX_BITS pixels MSB-first into BUS_BITS DDR write words,
// sequencing FIFO reset, base-address load and frame geometry from vsync.
module video_pix_packer #(
   parameter int unsigned ADDR_BITS    = 25,
   parameter int unsigned PIX_BITS     = 24,
   parameter int unsigned BUS_BITS     = 64,
   parameter string       BROADEN_LOAD = "FALSE",
   parameter int unsigned START_LAT    = 4
) (
   input  logic                 pclk,
   input  logic                 prst_n,
   input  logic                 vsync,
   input  logic                 de,
   input  logic [PIX_BITS-1:0]  indata,
   input  logic [ADDR_BITS-1:0] baseaddr,
   input  logic [23:0]          video_width,
   input  logic [11:0]          video_height,
   input  logic                 sync_fifo_empty,
   output logic                 fifo_empty,
   output logic                 wr_fifo_en,
   output logic [BUS_BITS-1:0]  wr_data,
   output logic                 arst_fifo,
   output logic                 loadbase,
   output logic [ADDR_BITS-1:0] ddr_baseaddr,
   output logic [23:0]          ddr_line_length,
   output logic [11:0]          ddr_col_length,
   output logic                 frame_done
);

   localparam int unsigned ACC_W = BUS_BITS + PIX_BITS;
   localparam int unsigned NB_W  = $clog2(ACC_W + 1);
   localparam int unsigned SH    = $clog2(BUS_BITS);
   localparam int unsigned LAT   = (START_LAT < 1) ? 1 : START_LAT;
   localparam int unsigned LAT_W = $clog2(LAT + 1);
   localparam logic [2:0]  FRM_LAST = (BROADEN_LOAD == "TRUE") ? 3'd5 : 3'd0;

   typedef enum logic [2:0] {IDLE, FRAME, LINE, LEND, FEND} state_t;

   state_t               state, state_nx;
   logic                 vsync_d;
   logic                 vs_rise, vs_fall;
   logic [23:0]          wid;
   logic [11:0]          hgt, hgt_eff;
   logic [35:0]          prod;
   logic [ADDR_BITS-1:0] base_lat;
   logic [LAT_W-1:0]     lat_cnt;
   logic                 armed, start_now;
   logic [2:0]           frm_cnt;
   logic [23:0]          pix_cnt;
   logic [11:0]          line_cnt;
   logic                 last_pix, last_line;
   logic                 take, fd_p0, load_frame;
   logic [ACC_W-1:0]     acc, acc_nx;
   logic [NB_W-1:0]      nbits, nbits_nx;
   logic                 emit;
   logic [BUS_BITS-1:0]  emit_data;
   logic                 s1_vld, s1_fd, fd_d2;
   logic [BUS_BITS-1:0]  s1_data;

   assign vs_rise        = vsync & ~vsync_d;
   assign vs_fall        = ~vsync & vsync_d;
   assign fifo_empty     = sync_fifo_empty;
   assign arst_fifo      = (state == FRAME);
   assign loadbase       = (state == FRAME);
   assign ddr_col_length = hgt;
   assign hgt_eff        = (hgt == 12'd0) ? 12'd1 : hgt;
   assign last_pix       = ({1'b0, pix_cnt} + 25'd1) == {1'b0, wid};
   assign last_line      = (line_cnt + 12'd1) == hgt_eff;
   assign start_now      = (LAT == 1) ? vs_fall : (armed && lat_cnt == LAT_W'(1));

   always_comb begin
      state_nx   = state;
      take       = 1'b0;
      fd_p0      = 1'b0;
      load_frame = 1'b0;
      case (state)
         IDLE: if (start_now) begin
            state_nx   = FRAME;
            load_frame = 1'b1;
         end
         FRAME: if (frm_cnt == FRM_LAST) state_nx = LINE;
         LINE: begin
            if (wid == 24'd0) state_nx = LEND;
            else if (de) begin
               take = 1'b1;
               if (last_pix) state_nx = LEND;
            end
         end
         LEND: begin
            if (last_line) begin
               state_nx = FEND;
               fd_p0    = 1'b1;
            end else begin
               // a pixel arriving here already belongs to the next line
               state_nx = LINE;
               if (de && wid != 24'd0) begin
                  take = 1'b1;
                  if (last_pix) state_nx = LEND;
               end
            end
         end
         FEND: state_nx = FEND;
         default: state_nx = IDLE;
      endcase
      if (vs_rise) begin
         state_nx   = IDLE;
         take       = 1'b0;
         fd_p0      = 1'b0;
         load_frame = 1'b0;
      end
   end

   // Valid bits sit left-aligned in acc; the tail flushes before a same-cycle new pixel.
   always_comb begin
      acc_nx    = acc;
      nbits_nx  = nbits;
      emit      = 1'b0;
      emit_data = '0;
      if (state == LEND) begin
         if (nbits != '0 && !vs_rise) begin
            emit      = 1'b1;
            emit_data = acc[ACC_W-1 -: BUS_BITS];
         end
         acc_nx   = '0;
         nbits_nx = '0;
      end
      if (take) begin
         acc_nx   = acc_nx | (ACC_W'(indata) << (NB_W'(ACC_W - PIX_BITS) - nbits_nx));
         nbits_nx = nbits_nx + NB_W'(PIX_BITS);
         if (nbits_nx >= NB_W'(BUS_BITS)) begin
            emit      = 1'b1;
            emit_data = acc_nx[ACC_W-1 -: BUS_BITS];
            acc_nx    = acc_nx << BUS_BITS;
            nbits_nx  = nbits_nx - NB_W'(BUS_BITS);
         end
      end
   end

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state           <= IDLE;
         vsync_d         <= 1'b0;
         wid             <= '0;
         hgt             <= '0;
         prod            <= '0;
         ddr_line_length <= '0;
         base_lat        <= '0;
         ddr_baseaddr    <= '0;
         armed           <= 1'b0;
         lat_cnt         <= '0;
         frm_cnt         <= '0;
      end else begin
         state   <= state_nx;
         vsync_d <= vsync;
         if (vsync) begin
            wid <= video_width;
            hgt <= video_height;
         end
         prod            <= 36'(wid) * 36'(PIX_BITS);
         ddr_line_length <= 24'((prod + 36'(BUS_BITS - 1)) >> SH);
         if (vs_fall) base_lat <= baseaddr;
         if (load_frame) ddr_baseaddr <= vs_fall ? baseaddr : base_lat;
         if (vs_fall) begin
            armed   <= 1'b1;
            lat_cnt <= LAT_W'(LAT - 1);
         end else if (vsync) begin
            armed <= 1'b0;
         end else if (armed) begin
            if (lat_cnt <= LAT_W'(1)) armed <= 1'b0;
            else lat_cnt <= lat_cnt - 1'b1;
         end
         frm_cnt <= (state == FRAME) ? frm_cnt + 3'd1 : 3'd0;
      end
   end

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         pix_cnt    <= '0;
         line_cnt   <= '0;
         acc        <= '0;
         nbits      <= '0;
         s1_vld     <= 1'b0;
         s1_data    <= '0;
         s1_fd      <= 1'b0;
         fd_d2      <= 1'b0;
         wr_fifo_en <= 1'b0;
         wr_data    <= '0;
         frame_done <= 1'b0;
      end else begin
         if (vsync) pix_cnt <= '0;
         else if (take) pix_cnt <= last_pix ? 24'd0 : pix_cnt + 24'd1;
         if (vsync || state == FRAME) line_cnt <= '0;
         else if (state == LEND && !last_line) line_cnt <= line_cnt + 12'd1;
         if (vsync) begin
            acc   <= '0;
            nbits <= '0;
         end else begin
            acc   <= acc_nx;
            nbits <= nbits_nx;
         end
         s1_vld     <= emit;
         s1_data    <= emit_data;
         s1_fd      <= fd_p0;
         fd_d2      <= s1_fd;
         wr_fifo_en <= s1_vld;
         wr_data    <= s1_data;
         frame_done <= fd_d2;
      end
   end

endmodule

// File: tb/tb_video_pix_packer.sv
// Bench for video_pix_packer: 24/64 narrow-load and 16/128 broadened-load instances
// driven in parallel, checked each cycle against a bit-stream model plus literals.
module tb_video_pix_packer;

   typedef struct {
      int           cyc;
      logic [127:0] data;
   } ev_t;

   logic         clk = 1'b0;
   logic         prst_n, vsync, de, sync_fifo_empty;
   logic [23:0]  indata_a;
   logic [15:0]  indata_b;
   logic [24:0]  baseaddr;
   logic [23:0]  video_width;
   logic [11:0]  video_height;

   logic         fifo_empty_a, wr_fifo_en_a, arst_a, ld_a, frame_done_a;
   logic [63:0]  wr_data_a;
   logic [24:0]  ddr_base_a;
   logic [23:0]  line_len_a;
   logic [11:0]  col_len_a;
   logic         fifo_empty_b, wr_fifo_en_b, arst_b, ld_b, frame_done_b;
   logic [127:0] wr_data_b;
   logic [24:0]  ddr_base_b;
   logic [23:0]  line_len_b;
   logic [11:0]  col_len_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 0;
   int frm_lo = -100;

   ev_t  wq_a[$];
   ev_t  wq_b[$];
   int   fd_q[$];
   logic [127:0] got_a[$];
   logic [127:0] got_b[$];
   int   fd_cnt_a, fd_cnt_b, arst_cnt_a, arst_cnt_b;

   logic [255:0] macc[2];
   int   mn[2];
   int   mpix, mline, fw, fh;
   int   pw[2] = '{24, 16};
   int   bw[2] = '{64, 128};

   video_pix_packer #(.ADDR_BITS(25), .PIX_BITS(24), .BUS_BITS(64),
                      .BROADEN_LOAD("FALSE"), .START_LAT(4)) dut_a (
      .pclk(clk), .prst_n(prst_n), .vsync(vsync), .de(de), .indata(indata_a),
      .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
      .sync_fifo_empty(sync_fifo_empty), .fifo_empty(fifo_empty_a),
      .wr_fifo_en(wr_fifo_en_a), .wr_data(wr_data_a), .arst_fifo(arst_a),
      .loadbase(ld_a), .ddr_baseaddr(ddr_base_a), .ddr_line_length(line_len_a),
      .ddr_col_length(col_len_a), .frame_done(frame_done_a));

   video_pix_packer #(.ADDR_BITS(25), .PIX_BITS(16), .BUS_BITS(128),
                      .BROADEN_LOAD("TRUE"), .START_LAT(4)) dut_b (
      .pclk(clk), .prst_n(prst_n), .vsync(vsync), .de(de), .indata(indata_b),
      .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
      .sync_fifo_empty(sync_fifo_empty), .fifo_empty(fifo_empty_b),
      .wr_fifo_en(wr_fifo_en_b), .wr_data(wr_data_b), .arst_fifo(arst_b),
      .loadbase(ld_b), .ddr_baseaddr(ddr_base_b), .ddr_line_length(line_len_b),
      .ddr_col_length(col_len_b), .frame_done(frame_done_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   function automatic logic [255:0] lowmask(input int k);
      return (256'd1 << k) - 256'd1;
   endfunction

   function automatic logic [23:0] pa_of(input int n);
      return 24'((n + 1) * 24'h111111);
   endfunction

   function automatic logic [15:0] pb_of(input int n);
      return 16'((n + 1) * 16'h1111);
   endfunction

   // Reference: each line is a bit string cut into bus words; the last piece is zero padded.
   task automatic model_pix(input logic [23:0] pa, input logic [15:0] pb);
      ev_t e;
      for (int d = 0; d < 2; d++) begin
         macc[d] = (macc[d] << pw[d]) | ((d == 0) ? 256'(pa) : 256'(pb));
         mn[d] += pw[d];
         if (mn[d] >= bw[d]) begin
            e.cyc  = cyc + 2;
            e.data = 128'((macc[d] >> (mn[d] - bw[d])) & lowmask(bw[d]));
            if (d == 0) wq_a.push_back(e); else wq_b.push_back(e);
            mn[d] -= bw[d];
            macc[d] &= lowmask(mn[d]);
         end
      end
      mpix++;
      if (mpix == fw) begin
         for (int d = 0; d < 2; d++) begin
            if (mn[d] > 0) begin
               e.cyc  = cyc + 3;
               e.data = 128'((macc[d] << (bw[d] - mn[d])) & lowmask(bw[d]));
               if (d == 0) wq_a.push_back(e); else wq_b.push_back(e);
            end
            macc[d] = '0;
            mn[d]   = 0;
         end
         mpix = 0;
         mline++;
         if (mline == ((fh == 0) ? 1 : fh)) fd_q.push_back(cyc + 4);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (wq_a.size() > 0 && wq_a[0].cyc == cyc) begin
            chk("wr_en_a", 128'(wr_fifo_en_a), 128'd1);
            chk("wr_data_a", 128'(wr_data_a), wq_a[0].data);
            void'(wq_a.pop_front());
         end else chk("wr_en_a_idle", 128'(wr_fifo_en_a), 128'd0);
         if (wq_b.size() > 0 && wq_b[0].cyc == cyc) begin
            chk("wr_en_b", 128'(wr_fifo_en_b), 128'd1);
            chk("wr_data_b", wr_data_b, wq_b[0].data);
            void'(wq_b.pop_front());
         end else chk("wr_en_b_idle", 128'(wr_fifo_en_b), 128'd0);
         if (fd_q.size() > 0 && fd_q[0] == cyc) begin
            chk("frame_done_a", 128'(frame_done_a), 128'd1);
            chk("frame_done_b", 128'(frame_done_b), 128'd1);
            void'(fd_q.pop_front());
         end else begin
            chk("frame_done_a_idle", 128'(frame_done_a), 128'd0);
            chk("frame_done_b_idle", 128'(frame_done_b), 128'd0);
         end
         chk("arst_a", 128'(arst_a), 128'(cyc >= frm_lo && cyc < frm_lo + 1));
         chk("loadbase_a", 128'(ld_a), 128'(cyc >= frm_lo && cyc < frm_lo + 1));
         chk("arst_b", 128'(arst_b), 128'(cyc >= frm_lo && cyc < frm_lo + 6));
         chk("loadbase_b", 128'(ld_b), 128'(cyc >= frm_lo && cyc < frm_lo + 6));
         chk("fifo_empty", 128'(fifo_empty_a), 128'(sync_fifo_empty));
         if (wr_fifo_en_a) got_a.push_back(128'(wr_data_a));
         if (wr_fifo_en_b) got_b.push_back(wr_data_b);
         if (frame_done_a) fd_cnt_a++;
         if (frame_done_b) fd_cnt_b++;
         if (arst_a) arst_cnt_a++;
         if (arst_b) arst_cnt_b++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      sync_fifo_empty = cyc[0];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         de = 1'b0;
      end
   endtask

   task automatic send_pix(input int n);
      step();
      de       = 1'b1;
      indata_a = pa_of(n);
      indata_b = pb_of(n);
      model_pix(indata_a, indata_b);
   endtask

   task automatic start_frame(input int w, input int h, input logic [24:0] base);
      step();
      de           = 1'b0;
      vsync        = 1'b1;
      video_width  = 24'(w);
      video_height = 12'(h);
      baseaddr     = base;
      repeat (3) step();
      step();
      vsync  = 1'b0;
      frm_lo = cyc + 4;
      for (int d = 0; d < 2; d++) begin
         macc[d] = '0;
         mn[d]   = 0;
      end
      mpix = 0; mline = 0; fw = w; fh = h;
      got_a.delete(); got_b.delete();
      fd_cnt_a = 0; fd_cnt_b = 0; arst_cnt_a = 0; arst_cnt_b = 0;
      step();
      baseaddr = ~base;
      repeat (11) step();
   endtask

   initial begin
      prst_n = 1'b0; vsync = 1'b0; de = 1'b0; sync_fifo_empty = 1'b0;
      indata_a = '0; indata_b = '0; baseaddr = '0; video_width = '0; video_height = '0;
      repeat (3) step();
      chk("rst_wr_en", 128'(wr_fifo_en_a), 128'd0);
      chk("rst_line_len", 128'(line_len_a), 128'd0);
      chk("rst_col_len", 128'(col_len_a), 128'd0);
      chk("rst_base", 128'(ddr_base_a), 128'd0);
      prst_n = 1'b1;
      chk_en = 1'b1;

      // width 8, height 2, continuous de
      start_frame(8, 2, 25'h0ABCDE);
      chk("t1_line_len_a", 128'(line_len_a), 128'd3);
      chk("t1_line_len_b", 128'(line_len_b), 128'd1);
      chk("t1_col_len", 128'(col_len_a), 128'd2);
      chk("t1_base_a", 128'(ddr_base_a), 128'h0ABCDE);
      chk("t1_base_b", 128'(ddr_base_b), 128'h0ABCDE);
      chk("t1_arst_len_a", 128'(arst_cnt_a), 128'd1);
      chk("t1_arst_len_b", 128'(arst_cnt_b), 128'd6);
      for (int n = 0; n < 16; n++) send_pix(n);
      idle(8);
      chk("t1_words_a", 128'(got_a.size()), 128'd6);
      chk("t1_words_b", 128'(got_b.size()), 128'd2);
      chk("t1_word0_a", got_a[0], 128'h1111112222223333);
      chk("t1_fd_a", 128'(fd_cnt_a), 128'd1);
      chk("t1_fd_b", 128'(fd_cnt_b), 128'd1);

      // width 5, height 0 (one line), tail word
      start_frame(5, 0, 25'h1000000);
      chk("t2_line_len_a", 128'(line_len_a), 128'd2);
      chk("t2_col_len", 128'(col_len_a), 128'd0);
      for (int n = 0; n < 5; n++) send_pix(n);
      idle(8);
      chk("t2_words_a", 128'(got_a.size()), 128'd2);
      chk("t2_word1_a", got_a[1], 128'h3344444455555500);
      chk("t2_word0_b", got_b[0], {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 48'h0});
      chk("t2_fd_a", 128'(fd_cnt_a), 128'd1);

      // width 8 with an idle cycle after every pixel
      start_frame(8, 1, 25'h0000123);
      for (int n = 0; n < 8; n++) begin
         send_pix(n);
         idle(1);
      end
      idle(8);
      chk("t3_words_a", 128'(got_a.size()), 128'd3);
      chk("t3_word0_a", got_a[0], 128'h1111112222223333);
      chk("t3_word2_a", got_a[2], 128'h6666777777888888);

      // width 10: wide bus gets a tail
      start_frame(10, 1, 25'h0000456);
      chk("t4_line_len_a", 128'(line_len_a), 128'd4);
      chk("t4_line_len_b", 128'(line_len_b), 128'd2);
      for (int n = 0; n < 10; n++) send_pix(n);
      idle(8);
      chk("t4_word1_b", got_b[1], {16'h9999, 16'hAAAA, 96'h0});
      chk("t4_words_b", 128'(got_b.size()), 128'd2);

      // vsync rising after 3 pixels of a line
      start_frame(8, 2, 25'h0000789);
      for (int n = 0; n < 3; n++) send_pix(n);
      idle(2);
      step();
      vsync = 1'b1;
      de = 1'b1;
      repeat (3) step();
      idle(6);
      chk("t5_words_a", 128'(got_a.size()), 128'd1);
      chk("t5_words_b", 128'(got_b.size()), 128'd0);
      chk("t5_fd_a", 128'(fd_cnt_a), 128'd0);
      chk("t5_fd_b", 128'(fd_cnt_b), 128'd0);

      // asynchronous reset in the middle of a line
      start_frame(8, 2, 25'h0000ABC);
      for (int n = 0; n < 4; n++) send_pix(n);
      #2;
      prst_n = 1'b0;
      chk_en = 1'b0;
      sync_fifo_empty = 1'b0;
      #1;
      chk("r_wr_en_a", 128'(wr_fifo_en_a), 128'd0);
      chk("r_wr_data_a", 128'(wr_data_a), 128'd0);
      chk("r_wr_en_b", 128'(wr_fifo_en_b), 128'd0);
      chk("r_arst", 128'(arst_a), 128'd0);
      chk("r_loadbase", 128'(ld_a), 128'd0);
      chk("r_base", 128'(ddr_base_a), 128'd0);
      chk("r_line_len_a", 128'(line_len_a), 128'd0);
      chk("r_line_len_b", 128'(line_len_b), 128'd0);
      chk("r_col_len", 128'(col_len_a), 128'd0);
      chk("r_frame_done", 128'(frame_done_a), 128'd0);
      chk("r_fifo_empty", 128'(fifo_empty_a), 128'd0);
      wq_a.delete(); wq_b.delete(); fd_q.delete();
      frm_lo = -100;
      de = 1'b0;
      idle(2);
      prst_n = 1'b1;
      chk_en = 1'b1;
      idle(4);

      // recovery after reset
      start_frame(5, 1, 25'h0000DEF);
      for (int n = 0; n < 5; n++) send_pix(n);
      idle(8);
      chk("t6_word1_a", got_a[1], 128'h3344444455555500);
      chk("t6_fd_b", 128'(fd_cnt_b), 128'd1);

      chk("pending_a", 128'(wq_a.size()), 128'd0);
      chk("pending_b", 128'(wq_b.size()), 128'd0);
      chk("pending_fd", 128'(fd_q.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
